// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register-bank write-back path
//
// Purpose: register-bank geometry, the write-back request record and the
// grant identifiers used by the write-back arbiter and its round-robin core.
package regfile_pkg;

    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int CNT_W      = 16;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(NREG - 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rtl/regfile_wb_arbiter_rr_arb2.sv - two-requester round-robin arbiter
//
// Purpose: grants one of two requesters per cycle; on a tie the requester
// that was not granted last wins. Nothing is granted while stall is high and
// the round-robin pointer only moves on an actual grant.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   req[1:0]       request vector, bit 0 = ALU, bit 1 = MEM
//   stall          suppress all grants this cycle
//   gnt[1:0]       zero or one-hot grant, same bit order as req
//   conflict       both requesters asked in a non-stalled cycle
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       stall,
    output logic [1:0] gnt,
    output logic       conflict
);

    grant_e last_grant;
    grant_e last_grant_nxt;

    // Reset to MEM so the ALU takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_MEM;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        gnt            = 2'b00;
        conflict       = 1'b0;
        last_grant_nxt = last_grant;
        if (!stall) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    conflict = 1'b1;
                    gnt      = (last_grant == GNT_MEM) ? 2'b01 : 2'b10;
                end
                default: gnt = 2'b00;
            endcase
            if (gnt[0]) begin
                last_grant_nxt = GNT_ALU;
            end else if (gnt[1]) begin
                last_grant_nxt = GNT_MEM;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter for the 32x64 register bank
//
// Purpose: arbitrates the ALU and load unit onto the bank's single write
// port, registers the winning write, drives one-hot enables and broadcast
// data, drops writes to the hardwired zero register, exposes the in-flight
// write for forwarding and counts arbitration conflicts.
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   alu_valid/ready/rd/data         ALU write-back handshake
//   mem_valid/ready/rd/data         load-unit write-back handshake
//   wb_stall                        no grants while high
//   write_en[NREG-2:0]              one-hot enable to bank registers 0..NREG-2
//   data_in[(NREG-1)*XLEN-1:0]      write data broadcast to every bank lane
//   fwd_valid/fwd_rd/fwd_data       registered write currently in flight
//   conflict_cnt[CNT_W-1:0]         saturating count of conflict cycles
module regfile_wb_arbiter #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREG  = regfile_pkg::NREG,
    parameter int CNT_W = regfile_pkg::CNT_W
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alu_valid,
    output logic                               alu_ready,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]                    alu_data,
    input  logic                               mem_valid,
    output logic                               mem_ready,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]                    mem_data,
    input  logic                               wb_stall,
    output logic [NREG-2:0]                    write_en,
    output logic [(NREG-1)*XLEN-1:0]           data_in,
    output logic                               fwd_valid,
    output logic [regfile_pkg::REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]                    fwd_data,
    output logic [CNT_W-1:0]                   conflict_cnt
);

    localparam int AW = regfile_pkg::REG_ADDR_W;
    localparam logic [AW-1:0] ZERO_RD = AW'(NREG - 1);

    logic [1:0]      gnt;
    logic            conflict;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            wr_live;
    logic [NREG-2:0] rd_onehot;
    logic [XLEN-1:0] data_q;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      ({mem_valid, alu_valid}),
        .stall    (wb_stall),
        .gnt      (gnt),
        .conflict (conflict)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];

    assign win_rd   = gnt[1] ? mem_rd   : alu_rd;
    assign win_data = gnt[1] ? mem_data : alu_data;

    // A grant to the zero register still completes the handshake but must
    // never reach the bank or the forwarding path.
    assign wr_live = (|gnt) && (win_rd != ZERO_RD);

    always_comb begin
        rd_onehot = '0;
        for (int i = 0; i < NREG - 1; i++) begin
            if (win_rd == AW'(i)) begin
                rd_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en     <= '0;
            fwd_valid    <= 1'b0;
            fwd_rd       <= '0;
            data_q       <= '0;
            conflict_cnt <= '0;
        end else begin
            write_en  <= wr_live ? rd_onehot : '0;
            fwd_valid <= wr_live;
            // Data and destination hold when nothing live is written so the
            // bank lanes do not toggle on idle cycles.
            if (wr_live) begin
                fwd_rd <= win_rd;
                data_q <= win_data;
            end
            if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    assign data_in  = {(NREG - 1){data_q}};
    assign fwd_data = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NW = NREG - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  alu_valid, mem_valid, wb_stall;
    logic                  alu_ready, mem_ready;
    logic [4:0]            alu_rd, mem_rd;
    logic [XLEN-1:0]       alu_data, mem_data;
    logic [NW-1:0]         write_en;
    logic [NW*XLEN-1:0]    data_in;
    logic                  fwd_valid;
    logic [4:0]            fwd_rd;
    logic [XLEN-1:0]       fwd_data;
    logic [CNT_W-1:0]      conflict_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .wb_stall     (wb_stall),
        .write_en     (write_en),
        .data_in      (data_in),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .conflict_cnt (conflict_cnt)
    );

    // Register bank driven by the DUT outputs.
    logic [XLEN-1:0] bank [0:NW-1] = '{default: '0};
    always @(posedge clk) begin
        for (int i = 0; i < NW; i++) begin
            if (write_en[i]) bank[i] <= data_in[i*XLEN +: XLEN];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: architectural contents plus the expected registered
    // output stage and the arbitration preference.
    logic [XLEN-1:0] arch [0:NW-1] = '{default: '0};
    bit              alu_first;
    int unsigned     m_cnt;
    logic [NW-1:0]   m_we;
    bit              m_fv;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    bit              acc_a, acc_m, s_ar, s_mr;

    task automatic model_reset();
        alu_first = 1'b1;
        m_cnt     = 0;
        m_we      = '0;
        m_fv      = 1'b0;
        m_rd      = '0;
        m_data    = '0;
    endtask

    task automatic cycle();
        bit ex_ar, ex_mr, bank_ok;
        int w_rd;
        logic [XLEN-1:0] w_data;
        @(negedge clk);
        ex_ar = !wb_stall && alu_valid && (!mem_valid || alu_first);
        ex_mr = !wb_stall && mem_valid && (!alu_valid || !alu_first);
        s_ar = alu_ready;
        s_mr = mem_ready;
        check("alu_ready", alu_ready, ex_ar);
        check("mem_ready", mem_ready, ex_mr);
        check("write_en", write_en, m_we);
        check("fwd_valid", fwd_valid, m_fv);
        check("fwd_rd", fwd_rd, m_rd);
        check("fwd_data", fwd_data, m_data);
        check("conflict_cnt", conflict_cnt, m_cnt);
        checks++;
        if (data_in !== {NW{m_data}}) begin
            errors++;
            $display("FAIL data_in: lane0 %0h expected all lanes %0h", data_in[XLEN-1:0], m_data);
        end
        bank_ok = 1'b1;
        for (int i = 0; i < NW; i++) if (bank[i] !== arch[i]) bank_ok = 1'b0;
        checks++;
        if (!bank_ok) begin
            errors++;
            $display("FAIL bank: contents differ from architectural model");
        end
        acc_a = ex_ar;
        acc_m = ex_mr;
        @(posedge clk);
        if (m_fv) arch[m_rd] = m_data;
        m_we = '0;
        m_fv = 1'b0;
        if (ex_ar || ex_mr) begin
            w_rd   = ex_ar ? int'(alu_rd) : int'(mem_rd);
            w_data = ex_ar ? alu_data : mem_data;
            if (w_rd != NREG - 1) begin
                m_we[w_rd] = 1'b1;
                m_fv       = 1'b1;
                m_rd       = 5'(w_rd);
                m_data     = w_data;
            end
        end
        if (ex_ar) alu_first = 1'b0;
        if (ex_mr) alu_first = 1'b1;
        if (!wb_stall && alu_valid && mem_valid && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alu_valid = 0; mem_valid = 0; wb_stall = 0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst write_en", write_en, 0);
        check("rst fwd_valid", fwd_valid, 0);
        check("rst fwd_rd", fwd_rd, 0);
        check("rst fwd_data", fwd_data, 0);
        check("rst conflict_cnt", conflict_cnt, 0);
        reset = 1'b0;
    endtask

    task automatic new_alu();
        alu_rd   = 5'($urandom_range(0, 31));
        alu_data = {$urandom, $urandom};
    endtask

    task automatic new_mem();
        mem_rd   = 5'($urandom_range(0, 31));
        mem_data = {$urandom, $urandom};
    endtask

    int ai, mi;
    logic [4:0] exp_seq [4];
    logic [CNT_W-1:0] cnt_hold;

    initial begin
        alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
        do_reset();

        // Single ALU write to r5.
        alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD;
        cycle();
        check("t1 alu_ready", s_ar, 1);
        alu_valid = 0;
        check("t1 write_en", write_en, 64'h20);
        check("t1 fwd_valid", fwd_valid, 1);
        check("t1 fwd_rd", fwd_rd, 5);
        check("t1 fwd_data", fwd_data, 64'hDEAD);
        cycle();
        check("t1 bank r5", bank[5], 64'hDEAD);

        // Dual requests: ALU r1..r4, MEM r11..r14, alternating grants.
        do_reset();
        exp_seq[0] = 1; exp_seq[1] = 11; exp_seq[2] = 2; exp_seq[3] = 12;
        ai = 0; mi = 0;
        for (int k = 0; k < 8; k++) begin
            alu_valid = (ai < 4); alu_rd = 5'(1 + ai);  alu_data = 64'(100 + ai);
            mem_valid = (mi < 4); mem_rd = 5'(11 + mi); mem_data = 64'(200 + mi);
            cycle();
            checks++;
            if (s_ar && s_mr) begin
                errors++;
                $display("FAIL both_ready: cycle %0d", k);
            end
            if (acc_a) ai++;
            if (acc_m) mi++;
            if (k < 4) check("t2 grant order", fwd_rd, exp_seq[k]);
            if (k == 3) check("t2 conflict_cnt", conflict_cnt, 4);
        end
        alu_valid = 0; mem_valid = 0;

        // MEM write to the zero register.
        mem_valid = 1; mem_rd = 31; mem_data = 64'hFFFF;
        cycle();
        check("t3 mem_ready", s_mr, 1);
        mem_valid = 0;
        check("t3 write_en", write_en, 0);
        check("t3 fwd_valid", fwd_valid, 0);
        cycle();

        // Stall with both valid, then release.
        cnt_hold = conflict_cnt;
        alu_valid = 1; alu_rd = 6; alu_data = 64'h66;
        mem_valid = 1; mem_rd = 16; mem_data = 64'h77;
        wb_stall = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t4 stall alu_ready", s_ar, 0);
            check("t4 stall mem_ready", s_mr, 0);
            check("t4 stall write_en", write_en, 0);
            check("t4 stall cnt", conflict_cnt, cnt_hold);
        end
        wb_stall = 0;
        cycle();
        check("t4 release alu first", s_ar, 1);
        alu_valid = 0;
        cycle();
        mem_valid = 0;
        cycle();

        // Asynchronous reset while a write to r7 is in flight.
        alu_valid = 1; alu_rd = 7; alu_data = 64'h1234_5678_9ABC_DEF0;
        cycle();
        alu_valid = 0;
        check("t5 write_en before rst", write_en, 64'h80);
        #1 reset = 1'b1;
        #1;
        check("t5 rst write_en", write_en, 0);
        check("t5 rst fwd_valid", fwd_valid, 0);
        check("t5 rst cnt", conflict_cnt, 0);
        model_reset();
        #1 reset = 1'b0;
        cycle();
        cycle();
        check("t5 r7 unwritten", bank[7], 0);

        // Saturation of the conflict counter under continuous dual requests.
        do_reset();
        alu_valid = 1; mem_valid = 1; new_alu(); new_mem();
        for (int k = 0; k < 65537; k++) begin
            cycle();
            if (acc_a) new_alu();
            if (acc_m) new_mem();
            if (k == 65533) check("t6 cnt near max", conflict_cnt, 16'hFFFE);
        end
        check("t6 cnt saturated", conflict_cnt, 16'hFFFF);
        alu_valid = 0; mem_valid = 0;
        cycle();

        // Randomized traffic with holding producers.
        for (int k = 0; k < 3000; k++) begin
            if (!alu_valid || acc_a) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                new_alu();
            end
            if (!mem_valid || acc_m) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                new_mem();
            end
            wb_stall = ($urandom_range(0, 7) == 0);
            cycle();
        end
        alu_valid = 0; mem_valid = 0; wb_stall = 0;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single write-back path of the 32x64 register bank between two producers: the ALU and the load/memory unit.
- Uses round-robin on conflict with valid/ready handshakes.
- Registers the winning write and drives the bank's one-hot write enables and data bus. Register 31 is hardwired zero, so writes to it are discarded.
- Exposes the in-flight write for forwarding and counts arbitration conflicts.

Parameters:
- XLEN, 64, data width per register
- NREG, 32, architectural register count; register NREG-1 is the zero register
- CNT_W, 16, width of the saturating conflict counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU write-back request
- alu_ready  output  1  ALU request accepted this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- mem_valid  input  1  load-unit write-back request
- mem_ready  output  1  load request accepted this cycle
- mem_rd  input  5  load destination register
- mem_data  input  XLEN  load result
- wb_stall  input  1  freeze: no grants while high
- write_en  output  NREG-1  one-hot enable to bank registers 0..30
- data_in  output  (NREG-1)*XLEN  per-register write data to bank, same value broadcast to all 31 lanes
- fwd_valid  output  1  a registered write to a nonzero register is in flight
- fwd_rd  output  5  destination of the in-flight write
- fwd_data  output  XLEN  data of the in-flight write
- conflict_cnt  output  CNT_W  number of cycles in which both requesters were valid and not stalled; saturates at all-ones

Behaviour:
- Reset is asynchronous, active-high. During reset:
  - write_en=0, data_in=0
  - fwd_valid=0, fwd_rd=0, fwd_data=0
  - conflict_cnt=0
  - last_grant=MEM, so the ALU wins the first conflict
- Reset asserted mid-operation drops any registered write; the bank is not written.
- Handshake:
  - A requester holds valid, rd and data stable until it sees ready.
  - Transfer occurs in the cycle where valid and ready are both high.
  - ready is combinational from the valid inputs, wb_stall and last_grant. It never asserts without the matching valid.
- Grant rules in cycle N:
  - wb_stall=1: no ready, and last_grant is unchanged.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted, and conflict_cnt increments (saturating).
  - last_grant updates only on an actual grant.
  - At most one ready is high per cycle.
- Output stage, loaded at the rising edge ending cycle N:
  - If granted and rd!=31:
    - write_en = 1<<rd
    - every data_in lane = winning data
    - fwd_valid=1, fwd_rd=rd, fwd_data=data
  - If granted with rd==31: handshake completes, write_en=0, fwd_valid=0 (write silently discarded).
  - No grant: write_en=0, fwd_valid=0. data_in and fwd_data hold their previous value; fwd_rd holds as well.
- Latency:
  - The bank captures the write at the edge ending cycle N+1.
  - The value is readable from the bank in cycle N+2.
  - fwd_* covers cycle N+1.
- Sustained throughput is one write per cycle. Under continuous dual requests the grants alternate A,M,A,M.
- Same rd from both requesters in consecutive grants: both writes occur in grant order, and the last writer wins.
- write_en is always zero or one-hot; bit 31 does not exist on this interface.

Decomposition:
- Package regfile_pkg holds:
  - XLEN, NREG, REG_ADDR_W=5, ZERO_REG=31
  - typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;}
  - enum grant_e {GNT_ALU, GNT_MEM}
- Sub-module rr_arb2: 2-requester round-robin arbiter. Inputs: req[1:0], stall. Outputs: gnt[1:0], conflict. Holds last_grant internally, with asynchronous reset to GNT_MEM.
- regfile_wb_arbiter instantiates rr_arb2 and contains the output register, the one-hot decoder, the zero-register filter and the counter.

Test Plan:
- Reset, then ALU only: alu_rd=5, alu_data=0xDEAD, valid for 1 cycle.
  - alu_ready=1 in cycle N.
  - In N+1: write_en=0x0000_0020, fwd_valid=1, fwd_rd=5, fwd_data=0xDEAD.
  - Bank register 5 reads 0xDEAD in N+2.
- Both valid for 4 cycles: ALU rd=1..4 and MEM rd=11..14, each requester holding its request until ready.
  - Grants in order: A(rd=1), M(rd=11), A(rd=2), M(rd=12).
  - conflict_cnt=4, and no cycle has both readys high.
- MEM writes rd=31 with data 0xFFFF.
  - mem_ready=1.
  - Next cycle: write_en=0, fwd_valid=0.
  - Bank register 31 still reads 0.
- wb_stall=1 for 3 cycles with both requesters valid.
  - Both readys are 0, write_en=0, conflict_cnt unchanged.
  - After release, the ALU is granted first (last_grant unchanged).
- Grant to ALU rd=7 in cycle N; reset pulses asynchronously mid-cycle N+1.
  - write_en and fwd_valid drop to 0 immediately.
  - Register 7 is not written; conflict_cnt=0.
- Force conflict_cnt to all-ones minus 1, then drive 3 conflict cycles: the counter saturates at 0xFFFF.
